seg_scroll_ctrl: RTL and testbench

Scroll controller for the 4-digit active-low 7-segment display. It holds a message of up to 8 segment patterns and steps a display window across it at a programmable rate, driving hex3..hex0 directly. Software-style controls select run, pause, stop, direction and loop count. It replaces hard-wired per-message scroll state machines on the board top level.

---
 rtl/seg_scroll_ctrl.sv | 108 ++++++++++
 tb/tb_seg_scroll_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: scrolls an 8-slot active-low 7-segment message across four digits
module seg_scroll_ctrl #(
  parameter int DIV = 4
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_char,
  input  logic [3:0] len,
  input  logic [3:0] loops,
  input  logic       dir,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [3:0] pos,
  output logic       busy,
  output logic       wrap,
  output logic       done
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [CW-1:0] presc, presc_n;
  logic [3:0] p_n, len_l, len_n, loops_l, loops_n, lcnt, lcnt_n, last, step_p;
  logic wrap_n, done_n;
  logic [6:0] msg [8];
  logic [6:0] hex_n [4];
  assign busy = state != IDLE;
  assign last = len_l + 4'd3;
  assign step_p = dir ? (pos == 4'd0 ? last : pos - 4'd1) : (pos == last ? 4'd0 : pos + 4'd1);
  // j wraps to >= 28 when p + k < 4, so one compare against L covers both bounds
  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic [4:0] j;
    assign j = {1'b0, pos} + 5'(k) - 5'd4;
    assign hex_n[k] = j < {1'b0, len_l} ? msg[j[2:0]] : 7'h7F;
  end
  always_comb begin
    state_n = state;
    p_n = pos;
    presc_n = presc;
    lcnt_n = lcnt;
    len_n = len_l;
    loops_n = loops_l;
    wrap_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = RUN;
        len_n = len == 4'd0 ? 4'd1 : len > 4'd8 ? 4'd8 : len;
        loops_n = loops;
        lcnt_n = 4'd0;
        presc_n = '0;
      end
      RUN: if (stop) state_n = PAUSE;
      else if (presc == CW'(DIV - 1)) begin
        presc_n = '0;
        p_n = step_p;
        if (step_p == 4'd0) begin
          wrap_n = 1'b1;
          lcnt_n = lcnt + 4'd1;
          if (loops_l != 4'd0 && lcnt_n == loops_l) begin
            done_n = 1'b1;
            state_n = IDLE;
          end
        end
      end else presc_n = presc + CW'(1);
      PAUSE: if (stop) begin
        state_n = IDLE;
        p_n = 4'd0;
        presc_n = '0;
      end else if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state <= IDLE;
      pos <= 4'd0;
      presc <= '0;
      lcnt <= 4'd0;
      len_l <= 4'd1;
      loops_l <= 4'd0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pos <= p_n;
      presc <= presc_n;
      lcnt <= lcnt_n;
      len_l <= len_n;
      loops_l <= loops_n;
      wrap <= wrap_n;
      done <= done_n;
    end
  end
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) for (int i = 0; i < 8; i++) msg[i] <= 7'h7F;
    else if (wr_en) msg[wr_addr] <= wr_char;
  end
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) {hex3, hex2, hex1, hex0} <= {4{7'h7F}};
    else {hex3, hex2, hex1, hex0} <= {hex_n[3], hex_n[2], hex_n[1], hex_n[0]};
  end
endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// tb_seg_scroll_ctrl: scoreboard bench with a frame-arithmetic reference model
module tb_seg_scroll_ctrl;
  localparam int DIV = 4;
  logic ck = 0, rs = 1, wr_en = 0, dir = 0, start = 0, stop = 0;
  logic [2:0] wr_addr = 0;
  logic [6:0] wr_char = 0;
  logic [3:0] len = 0, loops = 0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] pos;
  logic busy, wrap, done;

  seg_scroll_ctrl #(.DIV(DIV)) dut (
    .ck(ck), .rs(rs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .len(len), .loops(loops), .dir(dir), .start(start), .stop(stop),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .pos(pos), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [3:0]  pos;
    logic        busy;
    logic        wrap;
    logic        done;
    logic [27:0] hex;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0;

  // model: mode 0 idle, 1 run, 2 pause; rem = edges left until the next step
  int mode, mp, rem, ml, mloops, mwraps;
  logic [6:0] mmsg [8];
  logic [6:0] pat [4];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; mp = 0; rem = DIV; ml = 1; mloops = 0; mwraps = 0;
    for (int i = 0; i < 8; i++) mmsg[i] = 7'h7F;
  endtask

  task automatic model_edge();
    logic [27:0] nh;
    bit w, d;
    obs_t o;
    w = 0; d = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = mp - 4 + k;
      nh[k*7 +: 7] = (j >= 0 && j < ml) ? mmsg[j] : 7'h7F;
    end
    if (mode == 0) begin
      if (start && !stop) begin
        mode = 1;
        ml = len < 1 ? 1 : (len > 8 ? 8 : int'(len));
        mloops = loops; mwraps = 0; rem = DIV;
      end
    end else if (mode == 1) begin
      if (stop) mode = 2;
      else begin
        rem--;
        if (rem == 0) begin
          rem = DIV;
          mp = dir ? (mp + ml + 3) % (ml + 4) : (mp + 1) % (ml + 4);
          if (mp == 0) begin
            w = 1;
            mwraps = (mwraps + 1) % 16;
            if (mloops != 0 && mwraps == mloops) begin
              d = 1;
              mode = 0;
            end
          end
        end
      end
    end else begin
      if (stop) begin
        mode = 0; mp = 0;
      end else if (start) mode = 1;
    end
    if (wr_en) mmsg[wr_addr] = wr_char;
    o.pos = 4'(mp); o.busy = mode != 0; o.wrap = w; o.done = d; o.hex = nh;
    exp_q.push_back(o);
  endtask

  task automatic cyc();
    @(posedge ck);
    model_edge();
    @(negedge ck);
  endtask

  task automatic wait_pos(int v);
    int n;
    n = 0;
    while (mp != v && n < 400) begin
      cyc();
      n++;
    end
    if (mp != v) begin
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", mp, v);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_hex"}, {hex3, hex2, hex1, hex0}, {4{7'h7F}});
    chk({tag, "_pos"}, pos, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic rst_mid();
    #2 rs = 0;
    #1 check_reset_outputs("rst_mid");
    rs = 1;
    exp_q.delete();
    model_reset();
    {start, stop, wr_en} = 0;
    cyc();
  endtask

  task automatic go(int l, int lp, bit d);
    len = 4'(l); loops = 4'(lp); dir = d;
    start = 1; cyc(); start = 0;
  endtask

  task automatic abort();
    stop = 1; cyc(); cyc(); stop = 0; cyc();
  endtask

  always @(negedge ck) begin
    obs_t e;
    if (rs && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pos", pos, e.pos);
      chk("busy", busy, e.busy);
      chk("wrap", wrap, e.wrap);
      chk("done", done, e.done);
      chk("hex", {hex3, hex2, hex1, hex0}, e.hex);
    end
  end

  initial begin
    pat[0] = 7'h08; pat[1] = 7'h42; pat[2] = 7'h0C; pat[3] = 7'h0E;
    model_reset();
    #1 rs = 0;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(negedge ck);
    rs = 1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_char = pat[i]; cyc();
    end
    wr_en = 0;
    go(4, 0, 0); repeat (70) cyc(); abort();
    go(4, 2, 0); repeat (70) cyc();
    go(0, 0, 1); repeat (30) cyc(); abort();
    go(12, 0, 1); repeat (60) cyc(); abort();
    go(4, 0, 0); wait_pos(3);
    stop = 1; cyc(); stop = 0;
    repeat (20) cyc();
    start = 1; cyc(); start = 0;
    repeat (12) cyc();
    abort();
    go(4, 0, 0); repeat (5) cyc();
    stop = 1; cyc(); stop = 0; cyc();
    start = 1; stop = 1; cyc(); {start, stop} = 0;
    repeat (3) cyc();
    go(4, 0, 0); wait_pos(4);
    wr_en = 1; wr_addr = 0; wr_char = 7'h79; cyc(); wr_en = 0;
    repeat (3) cyc();
    abort();
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom % 8) == 0;
      stop = ($urandom % 16) == 0;
      if ($urandom % 32 == 0) dir = 1'($urandom);
      wr_en = ($urandom % 4) == 0;
      wr_addr = 3'($urandom);
      wr_char = 7'($urandom);
      len = 4'($urandom);
      loops = 4'($urandom % 4);
      cyc();
    end
    {start, stop, wr_en} = 0;
    cyc();
    go(8, 0, 0); repeat (10) cyc();
    rst_mid();
    go(8, 0, 0); repeat (50) cyc();
    abort();
    @(negedge ck);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
